fp_add_sched: RTL and testbench

Shared single-precision (IEEE-754 binary32 layout) floating-point adder with an integrated round-robin scheduler. Up to NREQ requesters present operand pairs. The block grants one pair at a time and runs it through an iterative align/add/normalise datapath, one shift per cycle. It returns the sum tagged with the requester index. It replaces per-requester combinational adders where area matters more than latency.

---
 rtl/fp_add_sched.sv | 214 +++++++++++++++++++++
 tb/tb_fp_add_sched.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/fp_add_sched.sv
// Shared binary32 adder with a round-robin front end: one operand pair at a time,
// aligned and normalised one shift per cycle, result tagged with the requester index.
//
// state | meaning
// IDLE  | waiting for any req_valid; grants and unpacks on the accept edge
// ALIGN | shifting the small mantissa right until the exponents match
// ADD   | 25-bit add/subtract of the aligned mantissas
// NORM  | one normalisation step per edge, then pack
// DONE  | presents out_valid for one cycle, then returns to IDLE
module fp_add_sched #(
    parameter int NREQ = 2,
    parameter int TAGW = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [32*NREQ-1:0]   req_a,
    input  logic [32*NREQ-1:0]   req_b,
    output logic [NREQ-1:0]      req_ready,
    output logic                 busy,
    output logic                 out_valid,
    output logic [31:0]          out_result,
    output logic [TAGW-1:0]      out_tag
);

    typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_ADD, S_NORM, S_DONE} state_t;

    state_t            state_q;
    logic [TAGW-1:0]   rr_q;
    logic [TAGW-1:0]   tag_q;
    logic              sign_b_q;
    logic              sign_s_q;
    logic              sign_r_q;
    logic [8:0]        exp_b_q;
    logic [8:0]        exp_s_q;
    logic [23:0]       mant_b_q;
    logic [23:0]       mant_s_q;
    logic [24:0]       sum_q;
    logic [31:0]       res_q;
    logic [NREQ-1:0]   req_ready_q;
    logic              busy_q;
    logic              out_valid_q;
    logic [31:0]       out_result_q;
    logic [TAGW-1:0]   out_tag_q;

    logic              gnt_any_d;
    logic [TAGW-1:0]   gnt_idx_d;
    logic [NREQ-1:0]   gnt_vec_d;
    logic [31:0]       op_a_d;
    logic [31:0]       op_b_d;

    // Two passes give the wrapped search order rr+1 .. NREQ-1, 0 .. rr.
    always_comb begin
        gnt_any_d = 1'b0;
        gnt_idx_d = '0;
        gnt_vec_d = '0;
        op_a_d    = '0;
        op_b_d    = '0;
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!gnt_any_d && req_valid[i] && ((pass == 0) == (i > int'(rr_q)))) begin
                    gnt_any_d    = 1'b1;
                    gnt_idx_d    = TAGW'(i);
                    gnt_vec_d[i] = 1'b1;
                    op_a_d       = req_a[32*i +: 32];
                    op_b_d       = req_b[32*i +: 32];
                end
            end
        end
    end

    logic [7:0]  exp_a_d;
    logic [7:0]  exp_bop_d;
    logic        a_big_d;
    logic        zero_any_d;
    logic [31:0] zero_res_d;
    logic [8:0]  exp_diff_d;

    always_comb begin
        exp_a_d    = op_a_d[30:23];
        exp_bop_d  = op_b_d[30:23];
        a_big_d    = (exp_a_d >= exp_bop_d);
        zero_any_d = (exp_a_d == 8'd0) || (exp_bop_d == 8'd0);
        if (exp_a_d == 8'd0 && exp_bop_d == 8'd0) begin
            zero_res_d = 32'h0000_0000;
        end else if (exp_a_d == 8'd0) begin
            zero_res_d = op_b_d;
        end else begin
            zero_res_d = op_a_d;
        end
        exp_diff_d = exp_b_q - exp_s_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            rr_q         <= TAGW'(NREQ - 1);
            tag_q        <= '0;
            sign_b_q     <= 1'b0;
            sign_s_q     <= 1'b0;
            sign_r_q     <= 1'b0;
            exp_b_q      <= '0;
            exp_s_q      <= '0;
            mant_b_q     <= '0;
            mant_s_q     <= '0;
            sum_q        <= '0;
            res_q        <= '0;
            req_ready_q  <= '0;
            busy_q       <= 1'b0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_tag_q    <= '0;
        end else begin
            req_ready_q <= '0;
            out_valid_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (gnt_any_d) begin
                        req_ready_q <= gnt_vec_d;
                        rr_q        <= gnt_idx_d;
                        tag_q       <= gnt_idx_d;
                        busy_q      <= 1'b1;
                        res_q       <= zero_res_d;
                        if (a_big_d) begin
                            sign_b_q <= op_a_d[31];
                            exp_b_q  <= {1'b0, exp_a_d};
                            mant_b_q <= {1'b1, op_a_d[22:0]};
                            sign_s_q <= op_b_d[31];
                            exp_s_q  <= {1'b0, exp_bop_d};
                            mant_s_q <= {1'b1, op_b_d[22:0]};
                        end else begin
                            sign_b_q <= op_b_d[31];
                            exp_b_q  <= {1'b0, exp_bop_d};
                            mant_b_q <= {1'b1, op_b_d[22:0]};
                            sign_s_q <= op_a_d[31];
                            exp_s_q  <= {1'b0, exp_a_d};
                            mant_s_q <= {1'b1, op_a_d[22:0]};
                        end
                        state_q <= zero_any_d ? S_DONE : S_ALIGN;
                    end
                end
                S_ALIGN: begin
                    if (exp_diff_d == 9'd0) begin
                        state_q <= S_ADD;
                    end else if (exp_diff_d > 9'd24) begin
                        mant_s_q <= '0;
                        exp_s_q  <= exp_b_q;
                    end else begin
                        mant_s_q <= mant_s_q >> 1;
                        exp_s_q  <= exp_s_q + 9'd1;
                    end
                end
                S_ADD: begin
                    if (sign_b_q == sign_s_q) begin
                        sum_q    <= {1'b0, mant_b_q} + {1'b0, mant_s_q};
                        sign_r_q <= sign_b_q;
                    end else if (mant_b_q >= mant_s_q) begin
                        sum_q    <= {1'b0, mant_b_q} - {1'b0, mant_s_q};
                        sign_r_q <= sign_b_q;
                    end else begin
                        sum_q    <= {1'b0, mant_s_q} - {1'b0, mant_b_q};
                        sign_r_q <= sign_s_q;
                    end
                    state_q <= S_NORM;
                end
                S_NORM: begin
                    // Terminal branches publish the result on the edge that enters DONE.
                    if (sum_q[24]) begin
                        if (exp_b_q >= 9'd254) begin
                            out_result_q <= {sign_r_q, 8'hFF, 23'd0};
                        end else begin
                            out_result_q <= {sign_r_q, exp_b_q[7:0] + 8'd1, sum_q[23:1]};
                        end
                        out_valid_q <= 1'b1;
                        out_tag_q   <= tag_q;
                        state_q     <= S_DONE;
                    end else if (sum_q == 25'd0 || (!sum_q[23] && exp_b_q <= 9'd1)) begin
                        out_result_q <= 32'h0000_0000;
                        out_valid_q  <= 1'b1;
                        out_tag_q    <= tag_q;
                        state_q      <= S_DONE;
                    end else if (sum_q[23]) begin
                        out_result_q <= {sign_r_q, exp_b_q[7:0], sum_q[22:0]};
                        out_valid_q  <= 1'b1;
                        out_tag_q    <= tag_q;
                        state_q      <= S_DONE;
                    end else begin
                        sum_q   <= sum_q << 1;
                        exp_b_q <= exp_b_q - 9'd1;
                    end
                end
                S_DONE: begin
                    // Zero-operand shortcut arrives without out_valid and strobes it here.
                    if (!out_valid_q) begin
                        out_valid_q  <= 1'b1;
                        out_result_q <= res_q;
                        out_tag_q    <= tag_q;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign req_ready  = req_ready_q;
    assign busy       = busy_q;
    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign out_tag    = out_tag_q;

endmodule

// File: tb/tb_fp_add_sched.sv
// Scoreboard bench for fp_add_sched: directed operand pairs push expected
// {tag, result, latency}; a monitor pops and compares on every out_valid.
module tb_fp_add_sched;

    localparam int NREQ = 2;
    localparam int TAGW = 2;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [NREQ-1:0]     req_valid = '0;
    logic [32*NREQ-1:0]  req_a = '0;
    logic [32*NREQ-1:0]  req_b = '0;
    logic [NREQ-1:0]     req_ready;
    logic                busy;
    logic                out_valid;
    logic [31:0]         out_result;
    logic [TAGW-1:0]     out_tag;

    fp_add_sched #(.NREQ(NREQ), .TAGW(TAGW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ready  (req_ready),
        .busy       (busy),
        .out_valid  (out_valid),
        .out_result (out_result),
        .out_tag    (out_tag)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] tag;
        logic [31:0] res;
        int          lat;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   last_accept = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    task automatic push_exp(input int tag, input logic [31:0] res, input int lat);
        exp_t e;
        e.tag = 32'(tag);
        e.res = res;
        e.lat = lat;
        sb_q.push_back(e);
    endtask

    // Monitor: accept tracking plus scoreboard comparison.
    initial begin
        forever begin
            exp_t e;
            @(negedge clk);
            if (req_ready != '0) begin
                check("ready_onehot", 32'($countones(req_ready)), 32'd1);
                last_accept = cyc;
            end
            if (out_valid) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out_valid: got result %h tag %0d, expected none", out_result, out_tag);
                end else begin
                    e = sb_q.pop_front();
                    check("result", out_result, e.res);
                    check("tag", 32'(out_tag), e.tag);
                    if (e.lat >= 0) check("latency", 32'(cyc - last_accept), 32'(e.lat));
                end
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic wait_accept(input int idx);
        int n = 0;
        while (!req_ready[idx] && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("accept_timeout", 32'(req_ready[idx]), 32'd1);
    endtask

    task automatic run_op(input int idx, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] res, input int lat);
        push_exp(idx, res, lat);
        req_a[32*idx +: 32] = a;
        req_b[32*idx +: 32] = b;
        req_valid[idx] = 1'b1;
        @(negedge clk);
        wait_accept(idx);
        req_valid[idx] = 1'b0;
        wait_idle();
    endtask

    initial begin
        int accepts;
        int n;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_result", out_result, 32'd0);
        check("rst_out_tag", 32'(out_tag), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Both requesters held: grants must alternate starting with requester 0.
        req_a = {32'h3FC0_0000, 32'h4128_0000};
        req_b = {32'h3FC0_0000, 32'h4050_0000};
        push_exp(0, 32'h415C_0000, 5);
        push_exp(1, 32'h4040_0000, 3);
        push_exp(0, 32'h415C_0000, 5);
        push_exp(1, 32'h4040_0000, 3);
        req_valid = 2'b11;
        accepts = 0;
        n = 0;
        while (accepts < 4 && n < 400) begin
            @(negedge clk);
            n++;
            if (req_ready != '0) accepts++;
        end
        req_valid = '0;
        check("fair_accept_count", 32'(accepts), 32'd4);
        wait_idle();

        run_op(0, 32'hC128_0000, 32'h4050_0000, 32'hC0E8_0000, 6);
        run_op(1, 32'h4000_0000, 32'hC000_0000, 32'h0000_0000, 3);
        run_op(0, 32'h7F7F_FFFF, 32'h7F7F_FFFF, 32'h7F80_0000, 3);
        run_op(1, 32'h0000_0000, 32'h4128_0000, 32'h4128_0000, 1);
        run_op(0, 32'hC000_0000, 32'h0000_0000, 32'hC000_0000, 1);
        run_op(1, 32'h8000_0000, 32'h0000_0000, 32'h0000_0000, 1);
        run_op(0, 32'h4B80_0000, 32'h3F80_0000, 32'h4B80_0000, 27);
        run_op(1, 32'h4C00_0000, 32'h3F80_0000, 32'h4C00_0000, 4);
        run_op(0, 32'h3FC0_0000, 32'hBFA0_0000, 32'h3E80_0000, 5);
        run_op(1, 32'h3FA0_0000, 32'hBFC0_0000, 32'hBE80_0000, 5);

        // Abort a d=2 operation in ALIGN; nothing may be pushed for it.
        req_a[31:0] = 32'h4128_0000;
        req_b[31:0] = 32'h4050_0000;
        req_valid[0] = 1'b1;
        @(negedge clk);
        wait_accept(0);
        req_valid[0] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_req_ready", 32'(req_ready), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_out_result", out_result, 32'd0);
        check("abort_out_tag", 32'(out_tag), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        check("abort_busy_after", 32'(busy), 32'd0);
        run_op(1, 32'h3FC0_0000, 32'h3FC0_0000, 32'h4040_0000, 3);

        n = 0;
        while (sb_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
